// File: rtl/logic_unit_seq.sv
// Digit-serial bitwise logic unit: evaluates op(A, B) W bits per clock, lowest chunk first,
// under a start/busy/done handshake, with a zero flag on the completed result.
module logic_unit_seq #(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] C,
  output logic         zero
);

  localparam int K  = N / W;
  localparam int IW = $clog2(K + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if ((N % W) != 0) begin : g_bad_width
    $error("logic_unit_seq: N (%0d) must be an integer multiple of W (%0d)", N, W);
  end

  function automatic logic [W-1:0] apply_op(input logic [2:0] o,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    case (o)
      3'b000:  apply_op = a & b;
      3'b001:  apply_op = a | b;
      3'b010:  apply_op = a ^ b;
      3'b011:  apply_op = ~(a | b);
      3'b100:  apply_op = ~(a & b);
      3'b101:  apply_op = ~(a ^ b);
      3'b110:  apply_op = a & ~b;
      default: apply_op = a;
    endcase
  endfunction

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [2:0]    op_q, op_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  c_q, c_d;
  logic          nz_q, nz_d;
  logic          zero_q, zero_d;

  logic [31:0]   shamt;
  logic [N-1:0]  a_sh, b_sh;
  logic [W-1:0]  chunk;
  logic          last;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    nz_d    = nz_q;
    zero_d  = zero_q;

    // Current chunk is brought down to bit 0 so the op function works on W bits only
    shamt = 32'(idx_q) * 32'(W);
    a_sh  = a_q >> shamt;
    b_sh  = b_q >> shamt;
    chunk = apply_op(op_q, a_sh[W-1:0], b_sh[W-1:0]);
    last  = (idx_q == IW'(K - 1));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          op_d    = op;
          c_d     = '0;
          idx_d   = '0;
          nz_d    = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // C was cleared on accept, so OR-ing the shifted chunk writes exactly that slice
        c_d   = c_q | (N'(chunk) << shamt);
        nz_d  = nz_q | (|chunk);
        idx_d = idx_q + IW'(1);
        if (last) begin
          zero_d  = ~(nz_q | (|chunk));
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      nz_q    <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      nz_q    <= nz_d;
      zero_q  <= zero_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign C    = c_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_logic_unit_seq.sv
// Bench for logic_unit_seq: directed and random operations on a 32/8 instance plus a
// single-chunk 16/16 instance, compared against a whole-word reference model.
module tb_logic_unit_seq;

  localparam int N = 32;
  localparam int W = 8;
  localparam int K = N / W;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        busy, done, zero;
  logic [31:0] C;

  logic        start16;
  logic [2:0]  op16;
  logic [15:0] A16, B16;
  logic        busy16, done16, zero16;
  logic [15:0] C16;

  int checks = 0;
  int errors = 0;

  logic done_prev   = 1'b0;
  logic done16_prev = 1'b0;

  always #5 clk = ~clk;

  logic_unit_seq #(.N(N), .W(W)) u_dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .C(C), .zero(zero)
  );

  logic_unit_seq #(.N(16), .W(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .op(op16), .A(A16), .B(B16),
    .busy(busy16), .done(done16), .C(C16), .zero(zero16)
  );

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    case (o)
      3'b000:  model = a & b;
      3'b001:  model = a | b;
      3'b010:  model = a ^ b;
      3'b011:  model = ~(a | b);
      3'b100:  model = ~(a & b);
      3'b101:  model = ~(a ^ b);
      3'b110:  model = a & ~b;
      default: model = a;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Handshake invariants on both instances, sampled on the falling edge
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      assert (!(busy && done) && !(done && done_prev) &&
              !(busy16 && done16) && !(done16 && done16_prev)) else begin
        errors++;
        $error("FAIL invariant: busy=%0b done=%0b prev=%0b busy16=%0b done16=%0b prev16=%0b",
               busy, done, done_prev, busy16, done16, done16_prev);
      end
    end
    done_prev   <= done;
    done16_prev <= done16;
  end

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_c, input bit scramble);
    int cyc;
    int nbusy;
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    nbusy = 0;
    while (!done && cyc < 40) begin
      if (busy) nbusy++;
      if (scramble) begin
        A  = $urandom;
        B  = $urandom;
        op = 3'($urandom_range(7, 0));
      end
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " done_seen"}, 32'(done), 32'd1);
    check({tag, " latency"}, 32'(cyc), 32'(K));
    check({tag, " busy_cycles"}, 32'(nbusy), 32'(K));
    check({tag, " C"}, C, exp_c);
    check({tag, " zero"}, 32'(zero), 32'(exp_c == 32'd0));
    @(posedge clk); #1;
    check({tag, " single_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone, first, lastc, seen;
    logic [31:0] ra, rb;
    logic [2:0]  ro;

    rst = 1'b1; start = 1'b0; op = '0; A = '0; B = '0;
    start16 = 1'b0; op16 = '0; A16 = '0; B16 = '0;
    #1;
    check("reset C", C, 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset zero", 32'(zero), 32'd0);
    check("reset16 C", 32'(C16), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("or",   3'b001, 32'hF0F0_0000, 32'h0F0F_00FF, 32'hFFFF_00FF, 1'b0);
    run_op("and",  3'b000, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000, 1'b0);
    run_op("nor",  3'b011, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000, 1'b0);
    run_op("xnor", 3'b101, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000, 1'b0);

    // Abort two cycles into an operation; zero is 1 beforehand so its reset is visible
    start = 1'b1; op = 3'b001; A = 32'h1357_9BDF; B = 32'h2468_ACE0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort C", C, 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort zero", 32'(zero), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    check("abort no_done", 32'(seen), 32'd0);

    run_op("passa", 3'b111, 32'hDEAD_BEEF, 32'h0123_4567, 32'hDEAD_BEEF, 1'b0);
    run_op("xor_scramble", 3'b010, 32'h1234_5678, 32'hFFFF_FFFF, 32'hEDCB_A987, 1'b1);

    // start held high: back-to-back accepts every K+2 cycles, one done each
    start = 1'b1; op = 3'b110; A = 32'hFFFF_0000; B = 32'h0F0F_0F0F;
    ndone = 0; first = -1; lastc = -1;
    for (int c = 0; c < 17; c++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (first < 0) first = c;
        lastc = c;
        check("andn C", C, 32'hF0F0_0000);
      end
    end
    start = 1'b0;
    check("andn done_count", 32'(ndone), 32'd3);
    check("andn first_done", 32'(first), 32'(K));
    check("andn period", 32'(lastc - first), 32'(2 * (K + 2)));
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      ro = 3'($urandom_range(7, 0));
      if (i == 0) rb = ra;
      run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, model(ro, ra, rb), 1'b0);
    end

    // Single-chunk instance: done in the cycle after the first RUN edge
    start16 = 1'b1; op16 = 3'b100; A16 = 16'hFF00; B16 = 16'h0FF0;
    @(posedge clk); #1;
    start16 = 1'b0;
    check("w16 busy", 32'(busy16), 32'd1);
    check("w16 early_done", 32'(done16), 32'd0);
    @(posedge clk); #1;
    check("w16 done", 32'(done16), 32'd1);
    check("w16 C", 32'(C16), 32'h0000_F0FF);
    check("w16 zero", 32'(zero16), 32'd0);
    @(posedge clk); #1;
    check("w16 single_pulse", 32'(done16), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
